// File: rtl/regfile_pkg.sv
// Shared constants and arbiter state encoding for the register-file write-port slice.
package regfile_pkg;
    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 5;
    localparam int NUM_REGS   = 32;
    localparam int REG_ZERO   = 0;
    localparam int REG_STATUS = 30;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;
endpackage

// File: rtl/md_result_fifo.sv
// Small count-based FIFO holding late multdiv results ({reg, data}) until the write port is free.
module md_result_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         ctrl_reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback and queued multdiv
// results, with a starvation escape and a busy scoreboard for hazard detection.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DW           = DW_DEFAULT,
    parameter int AW           = AW_DEFAULT,
    parameter int MD_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_reg,
    input  logic [DW-1:0]       wb_data,
    output logic                wb_stall,
    input  logic                md_issue,
    input  logic [AW-1:0]       md_issue_reg,
    input  logic                md_valid,
    input  logic [AW-1:0]       md_reg,
    input  logic [DW-1:0]       md_data,
    output logic                md_ready,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                rf_we,
    output logic [AW-1:0]       rf_reg,
    output logic [DW-1:0]       rf_data
);
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    arb_state_t    state;
    arb_state_t    state_next;
    logic [SW-1:0] starve_cnt;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW+DW-1:0] fifo_head;
    logic [AW-1:0] head_reg;
    logic [DW-1:0] head_data;

    logic          grant_force;
    logic          grant_wb;
    logic          grant_md;
    logic          md_blocked;
    logic          force_entry;
    logic [NUM_REGS-1:0] busy_next;

    // r0 results are acknowledged but never stored.
    assign md_ready  = !fifo_full;
    assign fifo_push = md_valid && md_ready && (md_reg != AW'(REG_ZERO));
    assign fifo_pop  = grant_force || grant_md;
    assign head_reg  = fifo_head[AW+DW-1:DW];
    assign head_data = fifo_head[DW-1:0];

    md_result_fifo #(
        .W     (AW + DW),
        .DEPTH (MD_DEPTH)
    ) u_md_fifo (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .wdata      ({md_reg, md_data}),
        .rdata      (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign grant_force = (state == ST_FORCE) && !fifo_empty;
    assign grant_wb    = !grant_force && wb_valid && (wb_reg != AW'(REG_ZERO));
    assign grant_md    = !grant_force && !grant_wb && !fifo_empty;
    assign md_blocked  = grant_wb && !fifo_empty;
    assign force_entry = (state == ST_NORMAL) && (state_next == ST_FORCE);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) state <= ST_NORMAL;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_NORMAL: if (md_blocked && starve_cnt == SW'(STARVE_LIMIT - 1)) state_next = ST_FORCE;
            ST_FORCE:  state_next = ST_NORMAL;
            default:   state_next = ST_NORMAL;
        endcase
    end

    always_comb begin
        wb_stall = (state == ST_FORCE);
        rf_we    = 1'b0;
        rf_reg   = '0;
        rf_data  = '0;
        if (fifo_pop) begin
            rf_we   = 1'b1;
            rf_reg  = head_reg;
            rf_data = head_data;
        end else if (grant_wb) begin
            rf_we   = 1'b1;
            rf_reg  = wb_reg;
            rf_data = wb_data;
        end
    end

    // Counts consecutive cycles the FIFO head lost the port to the pipeline.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)      starve_cnt <= '0;
        else if (force_entry) starve_cnt <= '0;
        else if (md_blocked) starve_cnt <= starve_cnt + 1'b1;
        else if (fifo_pop)   starve_cnt <= '0;
    end

    // A new issue to a register wins over the retirement of its older result.
    always_comb begin
        busy_next = busy_mask;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (fifo_pop && head_reg == AW'(i))
                busy_next[i] = 1'b0;
            if (md_issue && md_issue_reg == AW'(i) && i != REG_ZERO)
                busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) busy_mask <= '0;
        else            busy_mask <= busy_next;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MD_DEPTH = 4;
    localparam int STARVE_LIMIT = 8;

    logic          clock = 1'b0;
    logic          ctrl_reset = 1'b1;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_reg = '0;
    logic [DW-1:0] wb_data = '0;
    logic          wb_stall;
    logic          md_issue = 1'b0;
    logic [AW-1:0] md_issue_reg = '0;
    logic          md_valid = 1'b0;
    logic [AW-1:0] md_reg = '0;
    logic [DW-1:0] md_data = '0;
    logic          md_ready;
    logic [31:0]   busy_mask;
    logic          rf_we;
    logic [AW-1:0] rf_reg;
    logic [DW-1:0] rf_data;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .MD_DEPTH(MD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
        .md_issue(md_issue), .md_issue_reg(md_issue_reg),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .busy_mask(busy_mask), .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data)
    );

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_busy;
    int          m_blocked;
    bit          m_force;

    logic          exp_we, exp_stall, exp_ready;
    logic [AW-1:0] exp_reg;
    logic [DW-1:0] exp_data;
    logic [31:0]   exp_busy;

    int checks = 0;
    int passes = 0;

    always @(negedge clock) begin
        if (!ctrl_reset)
            assert (!(wb_valid && wb_reg != '0 && busy_mask[wb_reg]))
            else $error("FAIL wb_to_busy reg %0d is busy", wb_reg);
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_q.delete();
        m_busy = '0;
        m_blocked = 0;
        m_force = 1'b0;
    endtask

    // Evaluates this cycle's expected outputs, then advances the model past the next edge.
    task automatic model_step();
        bit popped = 1'b0;
        exp_stall = m_force;
        exp_ready = (m_q.size() < MD_DEPTH);
        exp_busy  = m_busy;
        exp_we = 1'b0; exp_reg = '0; exp_data = '0;
        if (m_force) begin
            exp_we = 1'b1; exp_reg = m_q[0].r; exp_data = m_q[0].d;
            popped = 1'b1; m_force = 1'b0; m_blocked = 0;
        end else if (wb_valid && wb_reg != '0) begin
            exp_we = 1'b1; exp_reg = wb_reg; exp_data = wb_data;
            if (m_q.size() > 0) begin
                m_blocked++;
                if (m_blocked == STARVE_LIMIT) begin
                    m_force = 1'b1;
                    m_blocked = 0;
                end
            end
        end else if (m_q.size() > 0) begin
            exp_we = 1'b1; exp_reg = m_q[0].r; exp_data = m_q[0].d;
            popped = 1'b1; m_blocked = 0;
        end
        if (popped) begin
            m_busy[m_q[0].r] = 1'b0;
            void'(m_q.pop_front());
        end
        if (md_issue && md_issue_reg != '0) m_busy[md_issue_reg] = 1'b1;
        if (md_valid && exp_ready && md_reg != '0) m_q.push_back('{r: md_reg, d: md_data});
    endtask

    task automatic cycle(input logic wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic mi, input logic [AW-1:0] mir,
                         input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        @(posedge clock); #1;
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        md_issue = mi; md_issue_reg = mir;
        md_valid = mv; md_reg = mr; md_data = md;
        @(negedge clock);
        model_step();
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        @(posedge clock); #2;
        ctrl_reset = 1'b1;
        wb_valid = 1'b0; md_issue = 1'b0; md_valid = 1'b0;
        @(posedge clock); #1;
        ctrl_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy_mask !== 32'h0) $display("FAIL reset_busy got %h want 0", busy_mask); else passes++;
        checks++; if (md_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", md_ready); else passes++;
        checks++; if (wb_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", wb_stall); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b want 0", rf_we); else passes++;
        @(posedge clock); #1;
        ctrl_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_wb_write();
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0);
        checks++; if (rf_we !== 1'b1) $display("FAIL t1_we got %b want 1", rf_we); else passes++;
        checks++; if (rf_reg !== 5'd5) $display("FAIL t1_reg got %0d want 5", rf_reg); else passes++;
        checks++; if (rf_data !== 32'hDEADBEEF) $display("FAIL t1_data got %h want deadbeef", rf_data); else passes++;
        checks++; if (wb_stall !== 1'b0) $display("FAIL t1_stall got %b want 0", wb_stall); else passes++;
    endtask

    task automatic test_md_write();
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd7, 32'h1234);
        checks++; if (rf_we !== 1'b0) $display("FAIL t2_nobypass_we got %b want 0", rf_we); else passes++;
        checks++; if (busy_mask[7] !== 1'b1) $display("FAIL t2_busy_set got %b want 1", busy_mask[7]); else passes++;
        idle();
        checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd7, 32'h1234})
            $display("FAIL t2_write got we=%b reg=%0d data=%h want we=1 reg=7 data=1234", rf_we, rf_reg, rf_data); else passes++;
        checks++; if (busy_mask[7] !== 1'b1) $display("FAIL t2_busy_before got %b want 1", busy_mask[7]); else passes++;
        idle();
        checks++; if (busy_mask[7] !== 1'b0) $display("FAIL t2_busy_clear got %b want 0", busy_mask[7]); else passes++;
        checks++; if (rf_we !== 1'b0) $display("FAIL t2_idle_we got %b want 0", rf_we); else passes++;
    endtask

    task automatic test_starve();
        cycle(1'b1, 5'd3, 32'hA0, 1'b1, 5'd9, 1'b0, '0, '0);
        cycle(1'b1, 5'd3, 32'hA1, 1'b0, '0, 1'b1, 5'd9, 32'h55);
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            cycle(1'b1, 5'd3, 32'hB0 + k, 1'b0, '0, 1'b0, '0, '0);
            checks++; if ({wb_stall, rf_we, rf_reg} !== {1'b0, 1'b1, 5'd3})
                $display("FAIL t3_blocked%0d got stall=%b we=%b reg=%0d want stall=0 we=1 reg=3", k, wb_stall, rf_we, rf_reg); else passes++;
        end
        cycle(1'b1, 5'd3, 32'h77, 1'b0, '0, 1'b0, '0, '0);
        checks++; if ({wb_stall, rf_we, rf_reg, rf_data} !== {1'b1, 1'b1, 5'd9, 32'h55})
            $display("FAIL t3_force got stall=%b we=%b reg=%0d data=%h want stall=1 we=1 reg=9 data=55", wb_stall, rf_we, rf_reg, rf_data); else passes++;
        cycle(1'b1, 5'd3, 32'h77, 1'b0, '0, 1'b0, '0, '0);
        checks++; if ({wb_stall, rf_we, rf_reg, rf_data} !== {1'b0, 1'b1, 5'd3, 32'h77})
            $display("FAIL t3_resume got stall=%b we=%b reg=%0d data=%h want stall=0 we=1 reg=3 data=77", wb_stall, rf_we, rf_reg, rf_data); else passes++;
        checks++; if (busy_mask[9] !== 1'b0) $display("FAIL t3_busy9 got %b want 0", busy_mask[9]); else passes++;
    endtask

    task automatic test_fifo_full();
        logic [AW-1:0] drained[$];
        logic [AW-1:0] want;
        bit accepted = 1'b0;
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 5'd3, 32'h0, 1'b0, '0, 1'b1, 5'(10 + k), 32'(10 + k) << 8);
        cycle(1'b1, 5'd3, 32'h0, 1'b0, '0, 1'b1, 5'd14, 32'd14 << 8);
        checks++; if (md_ready !== 1'b0) $display("FAIL t4_full_ready got %b want 0", md_ready); else passes++;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, '0, '0, 1'b0, '0, !accepted, 5'd14, 32'd14 << 8);
            if (k == 0) begin
                checks++; if (md_ready !== 1'b0) $display("FAIL t4_full_hold got %b want 0", md_ready); else passes++;
            end
            if (md_valid && md_ready) accepted = 1'b1;
            if (rf_we) begin
                drained.push_back(rf_reg);
                checks++; if (rf_data !== (32'(rf_reg) << 8))
                    $display("FAIL t4_data got %h want %h", rf_data, 32'(rf_reg) << 8); else passes++;
            end
        end
        checks++; if (drained.size() != 5) $display("FAIL t4_drain_count got %0d want 5", drained.size()); else passes++;
        for (int k = 0; k < drained.size() && k < 5; k++) begin
            want = 5'(10 + k);
            checks++; if (drained[k] !== want) $display("FAIL t4_order%0d got %0d want %0d", k, drained[k], want); else passes++;
        end
    endtask

    task automatic test_r0();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 5'd0, 32'hF00D, 1'b1, 5'd0, 1'b1, 5'd0, 32'hBAD);
            checks++; if (rf_we !== 1'b0) $display("FAIL t5_we%0d got %b want 0", k, rf_we); else passes++;
            checks++; if (busy_mask[0] !== 1'b0) $display("FAIL t5_busy0_%0d got %b want 0", k, busy_mask[0]); else passes++;
        end
        idle();
        checks++; if ({rf_we, busy_mask[0], md_ready} !== 3'b001)
            $display("FAIL t5_after got we=%b busy0=%b ready=%b want 0 0 1", rf_we, busy_mask[0], md_ready); else passes++;
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 5'd3, 32'h1, 1'b1, 5'd20, 1'b1, 5'd20, 32'h20);
        cycle(1'b1, 5'd3, 32'h2, 1'b1, 5'd21, 1'b1, 5'd21, 32'h21);
        cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 1'b1, 5'd22, 32'h22);
        @(posedge clock); #1;
        checks++; if (busy_mask !== 32'h0070_0000) $display("FAIL t6_busy_pre got %h want 00700000", busy_mask); else passes++;
        #1;
        ctrl_reset = 1'b1;
        wb_valid = 1'b0; md_issue = 1'b0; md_valid = 1'b0;
        #1;
        checks++; if ({busy_mask, md_ready, rf_we} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL t6_async got busy=%h ready=%b we=%b want busy=0 ready=1 we=0", busy_mask, md_ready, rf_we); else passes++;
        @(posedge clock); #1;
        ctrl_reset = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            checks++; if ({rf_we, busy_mask} !== {1'b0, 32'h0})
                $display("FAIL t6_stale%0d got we=%b busy=%h want we=0 busy=0", k, rf_we, busy_mask); else passes++;
        end
    endtask

    task automatic test_random();
        logic          wv, mi, mv;
        logic [AW-1:0] wr, mir, mr;
        for (int n = 0; n < 400; n++) begin
            wr  = 5'($urandom_range(0, 31));
            wv  = ($urandom_range(0, 99) < 75) && !m_busy[wr];
            mi  = ($urandom_range(0, 99) < 30);
            mir = 5'($urandom_range(0, 31));
            mv  = ($urandom_range(0, 99) < 40);
            mr  = 5'($urandom_range(0, 31));
            cycle(wv, wr, $urandom, mi, mir, mv, mr, $urandom);
            checks++; if (rf_we !== exp_we) $display("FAIL rnd%0d_we got %b want %b", n, rf_we, exp_we); else passes++;
            if (exp_we) begin
                checks++; if (rf_reg !== exp_reg) $display("FAIL rnd%0d_reg got %0d want %0d", n, rf_reg, exp_reg); else passes++;
                checks++; if (rf_data !== exp_data) $display("FAIL rnd%0d_data got %h want %h", n, rf_data, exp_data); else passes++;
            end
            checks++; if (wb_stall !== exp_stall) $display("FAIL rnd%0d_stall got %b want %b", n, wb_stall, exp_stall); else passes++;
            checks++; if (md_ready !== exp_ready) $display("FAIL rnd%0d_ready got %b want %b", n, md_ready, exp_ready); else passes++;
            checks++; if (busy_mask !== exp_busy) $display("FAIL rnd%0d_busy got %h want %h", n, busy_mask, exp_busy); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_md_write();
        test_starve();
        apply_reset();
        test_fifo_full();
        test_r0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
